mac_pipe: RTL and testbench

- Parametrised, pipelined multiply-add unit: `data_out = a*b + c`, with an additional accumulate mode that sums products over a framed burst.
- Adds a valid handshake, a synchronous reset, signed/unsigned selection and an overflow flag to the fixed-width multiply-add datapath.
- Sits between sample sources and downstream filter/statistics logic.
- Fixed latency of 3 clocks; no backpressure.

---
 rtl/mac_par_pkg.sv | 16 +
 rtl/mac_mult.sv | 36 +++
 rtl/mac_pipe.sv | 160 ++++++++++++++++
 tb/tb_mac_pipe.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mac_par_pkg.sv
// Shared types and defaults for the pipelined multiply-add unit.
package mac_par;

  localparam int unsigned DefWidth    = 8;
  localparam int unsigned DefAccWidth = 2 * DefWidth + 4;

  typedef enum logic {MODE_MAC, MODE_ACC} mac_mode_t;

  typedef struct packed {
    logic      valid;
    mac_mode_t mode;
    logic      first;
    logic      last;
  } mac_ctl_t;

endpackage

// File: rtl/mac_mult.sv
// Registered WIDTHxWIDTH multiplier; signed or unsigned operands, full 2*WIDTH product.
module mac_mult
  import mac_par::*;
#(
  parameter int unsigned WIDTH  = DefWidth,
  parameter bit          SIGNED = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   prod
);

  logic [2*WIDTH-1:0] a_ext, b_ext;
  logic [2*WIDTH-1:0] prod_d, prod_q;

  // The low 2*WIDTH bits of the extended product equal the signed product.
  always_comb begin
    a_ext  = SIGNED ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    b_ext  = SIGNED ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
    prod_d = en ? (a_ext * b_ext) : prod_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q <= '0;
    end else begin
      prod_q <= prod_d;
    end
  end

  assign prod = prod_q;

endmodule

// File: rtl/mac_pipe.sv
// Three-stage multiply-add with framed accumulate mode, sticky overflow and busy flag.
module mac_pipe
  import mac_par::*;
#(
  parameter int unsigned WIDTH     = DefWidth,
  parameter int unsigned ACC_WIDTH = 2 * WIDTH + 4,
  parameter bit          SIGNED    = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic                 mode,
  input  logic                 first,
  input  logic                 last,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [WIDTH-1:0]     c,
  output logic                 out_valid,
  output logic [ACC_WIDTH-1:0] data_out,
  output logic                 ovf,
  output logic                 busy
);

  localparam int unsigned PW = 2 * WIDTH;

  if (ACC_WIDTH < 2 * WIDTH + 1) begin : g_bad_acc_width
    $error("ACC_WIDTH must be at least 2*WIDTH+1");
  end

  // Stage 1: operand and control capture.
  mac_ctl_t         s1_ctl_d, s1_ctl_q;
  logic [WIDTH-1:0] a_d, a_q, b_d, b_q, c1_d, c1_q;

  always_comb begin
    s1_ctl_d.valid = in_valid;
    s1_ctl_d.mode  = mac_mode_t'(mode);
    s1_ctl_d.first = first;
    s1_ctl_d.last  = last;
    a_d  = in_valid ? a : a_q;
    b_d  = in_valid ? b : b_q;
    c1_d = in_valid ? c : c1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_ctl_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c1_q     <= '0;
    end else begin
      s1_ctl_q <= s1_ctl_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c1_q     <= c1_d;
    end
  end

  // Stage 2: product register, with c and control delayed alongside.
  mac_ctl_t         s2_ctl_d, s2_ctl_q;
  logic [WIDTH-1:0] c2_d, c2_q;
  logic [PW-1:0]    prod;

  mac_mult #(
    .WIDTH  (WIDTH),
    .SIGNED (SIGNED)
  ) u_mult (
    .clk  (clk),
    .rst  (rst),
    .en   (s1_ctl_q.valid),
    .a    (a_q),
    .b    (b_q),
    .prod (prod)
  );

  always_comb begin
    s2_ctl_d = s1_ctl_q;
    c2_d     = s1_ctl_q.valid ? c1_q : c2_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_ctl_q <= '0;
      c2_q     <= '0;
    end else begin
      s2_ctl_q <= s2_ctl_d;
      c2_q     <= c2_d;
    end
  end

  // Stage 3: add / accumulate and output registers.
  logic [ACC_WIDTH-1:0] p_ext, c_ext, addend, sum;
  logic                 carry, add_ovf;
  logic [ACC_WIDTH-1:0] acc_d, acc_q, data_out_d, data_out_q;
  logic                 sticky_d, sticky_q, busy_d, busy_q;
  logic                 out_valid_d, out_valid_q, ovf_d, ovf_q;

  always_comb begin
    p_ext = SIGNED ? {{(ACC_WIDTH - PW){prod[PW-1]}}, prod}
                   : {{(ACC_WIDTH - PW){1'b0}}, prod};
    c_ext = SIGNED ? {{(ACC_WIDTH - WIDTH){c2_q[WIDTH-1]}}, c2_q}
                   : {{(ACC_WIDTH - WIDTH){1'b0}}, c2_q};

    // Mode 0 and accumulation starts add c; otherwise the running sum.
    addend = (s2_ctl_q.mode == MODE_MAC || s2_ctl_q.first) ? c_ext : acc_q;
    {carry, sum} = {1'b0, addend} + {1'b0, p_ext};
    add_ovf = SIGNED ? ((addend[ACC_WIDTH-1] == p_ext[ACC_WIDTH-1]) &&
                        (sum[ACC_WIDTH-1] != addend[ACC_WIDTH-1]))
                     : carry;

    acc_d       = acc_q;
    sticky_d    = sticky_q;
    busy_d      = busy_q;
    out_valid_d = 1'b0;
    data_out_d  = data_out_q;
    ovf_d       = ovf_q;

    if (s2_ctl_q.valid) begin
      if (s2_ctl_q.mode == MODE_MAC) begin
        out_valid_d = 1'b1;
        data_out_d  = sum;
        ovf_d       = 1'b0;
      end else begin
        acc_d    = sum;
        sticky_d = (s2_ctl_q.first ? 1'b0 : sticky_q) | add_ovf;
        if (s2_ctl_q.last) begin
          out_valid_d = 1'b1;
          data_out_d  = sum;
          ovf_d       = sticky_d;
          busy_d      = 1'b0;
        end else if (s2_ctl_q.first) begin
          busy_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      sticky_q    <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      data_out_q  <= '0;
      ovf_q       <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      sticky_q    <= sticky_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      data_out_q  <= data_out_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign data_out  = data_out_q;
  assign ovf       = ovf_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mac_pipe.sv
// Directed bench for mac_pipe: unsigned and signed instances share one stimulus bus.
module tb_mac_pipe;

  localparam int unsigned W  = 8;
  localparam int unsigned AW = 20;

  logic          clk = 1'b0;
  logic          rst, in_valid, mode, first, last;
  logic [W-1:0]  a, b, c;
  logic          ov, ovf, busy, s_ov, s_ovf, s_busy;
  logic [AW-1:0] dout, s_dout;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mac_pipe #(.WIDTH(W), .ACC_WIDTH(AW), .SIGNED(1'b0)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .mode(mode), .first(first), .last(last),
    .a(a), .b(b), .c(c), .out_valid(ov), .data_out(dout), .ovf(ovf), .busy(busy)
  );

  mac_pipe #(.WIDTH(W), .ACC_WIDTH(AW), .SIGNED(1'b1)) u_sdut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .mode(mode), .first(first), .last(last),
    .a(a), .b(b), .c(c), .out_valid(s_ov), .data_out(s_dout), .ovf(s_ovf), .busy(s_busy)
  );

  typedef struct {
    logic          m, f, l;
    logic [W-1:0]  a, b, c;
    logic [AW-1:0] d;
    logic          o;
  } vec_t;

  vec_t vt[7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic m, input logic f, input logic l,
                      input logic [W-1:0] aa, input logic [W-1:0] bb, input logic [W-1:0] cc);
    in_valid = 1'b1; mode = m; first = f; last = l; a = aa; b = bb; c = cc;
    step();
    in_valid = 1'b0;
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0b expected %0b", name, got, exp);
    end
  endtask

  task automatic chkd(input string name, input logic [AW-1:0] got, input logic [AW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  initial begin
    int cnt;
    logic [AW-1:0] seen;

    in_valid = 1'b0; mode = 1'b0; first = 1'b0; last = 1'b0;
    a = '0; b = '0; c = '0;
    do_reset();
    chk1("rst_out_valid", ov, 1'b0);
    chkd("rst_data_out", dout, 20'd0);
    chk1("rst_ovf", ovf, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_s_out_valid", s_ov, 1'b0);

    // Isolated beats; acc carries across the mode 1 rows, untouched by mode 0 rows.
    vt[0] = '{1'b0, 1'b0, 1'b0, 8'd200, 8'd250, 8'd255, 20'd50255, 1'b0};
    vt[1] = '{1'b0, 1'b0, 1'b0, 8'd255, 8'd255, 8'd255, 20'd65280, 1'b0};
    vt[2] = '{1'b0, 1'b0, 1'b0, 8'd0,   8'd0,   8'd0,   20'd0,     1'b0};
    vt[3] = '{1'b1, 1'b1, 1'b1, 8'd6,   8'd7,   8'd5,   20'd47,    1'b0};
    vt[4] = '{1'b1, 1'b0, 1'b1, 8'd2,   8'd3,   8'd99,  20'd53,    1'b0};
    vt[5] = '{1'b0, 1'b0, 1'b0, 8'd13,  8'd17,  8'd1,   20'd222,   1'b0};
    vt[6] = '{1'b1, 1'b0, 1'b1, 8'd1,   8'd1,   8'd0,   20'd54,    1'b0};
    for (int i = 0; i < 7; i++) begin
      beat(vt[i].m, vt[i].f, vt[i].l, vt[i].a, vt[i].b, vt[i].c);
      chk1($sformatf("vec%0d_early1", i), ov, 1'b0);
      step();
      chk1($sformatf("vec%0d_early2", i), ov, 1'b0);
      step();
      chk1($sformatf("vec%0d_valid", i), ov, 1'b1);
      chkd($sformatf("vec%0d_data", i), dout, vt[i].d);
      chk1($sformatf("vec%0d_ovf", i), ovf, vt[i].o);
      step();
      chk1($sformatf("vec%0d_drop", i), ov, 1'b0);
      chkd($sformatf("vec%0d_hold", i), dout, vt[i].d);
    end

    // Mode 0 back-to-back stream.
    beat(1'b0, 1'b0, 1'b0, 8'd1, 8'd2, 8'd3);
    beat(1'b0, 1'b0, 1'b0, 8'd4, 8'd5, 8'd6);
    beat(1'b0, 1'b0, 1'b0, 8'd7, 8'd8, 8'd9);
    chk1("stream0_v", ov, 1'b1); chkd("stream0_d", dout, 20'd5);
    beat(1'b0, 1'b0, 1'b0, 8'd10, 8'd11, 8'd12);
    chk1("stream1_v", ov, 1'b1); chkd("stream1_d", dout, 20'd26);
    step();
    chk1("stream2_v", ov, 1'b1); chkd("stream2_d", dout, 20'd65);
    step();
    chk1("stream3_v", ov, 1'b1); chkd("stream3_d", dout, 20'd122);
    step();
    chk1("stream_end_v", ov, 1'b0); chkd("stream_hold", dout, 20'd122);

    // Mode 1 burst, back to back.
    beat(1'b1, 1'b1, 1'b0, 8'd3, 8'd4, 8'd10);
    chk1("burst_busy_pre", busy, 1'b0);
    beat(1'b1, 1'b0, 1'b0, 8'd5, 8'd6, 8'd0);
    beat(1'b1, 1'b0, 1'b1, 8'd7, 8'd8, 8'd0);
    chk1("burst_busy_a", busy, 1'b1); chk1("burst_nov_a", ov, 1'b0);
    step();
    chk1("burst_busy_b", busy, 1'b1); chk1("burst_nov_b", ov, 1'b0);
    step();
    chk1("burst_v", ov, 1'b1); chkd("burst_d", dout, 20'd108);
    chk1("burst_ovf", ovf, 1'b0); chk1("burst_busy_end", busy, 1'b0);
    step();
    chk1("burst_single", ov, 1'b0);

    // Same burst with a bubble in the middle; count output pulses.
    beat(1'b1, 1'b1, 1'b0, 8'd3, 8'd4, 8'd10);
    step();
    beat(1'b1, 1'b0, 1'b0, 8'd5, 8'd6, 8'd0);
    beat(1'b1, 1'b0, 1'b1, 8'd7, 8'd8, 8'd0);
    cnt = (ov === 1'b1) ? 1 : 0;
    seen = dout;
    for (int i = 0; i < 6; i++) begin
      step();
      if (ov === 1'b1) begin
        cnt++;
        seen = dout;
      end
    end
    chkd("bubble_pulses", AW'(cnt), 20'd1);
    chkd("bubble_d", seen, 20'd108);

    // Overflow: 17 x 255*255 wraps a 20-bit accumulator.
    for (int i = 0; i < 17; i++) begin
      beat(1'b1, i == 0, i == 16, 8'd255, 8'd255, 8'd0);
    end
    step(); step();
    chk1("ovf_v", ov, 1'b1); chkd("ovf_d", dout, 20'd56849); chk1("ovf_flag", ovf, 1'b1);
    beat(1'b1, 1'b1, 1'b0, 8'd1, 8'd1, 8'd0);
    beat(1'b1, 1'b0, 1'b1, 8'd2, 8'd2, 8'd0);
    step(); step();
    chk1("ovf_clr_v", ov, 1'b1); chkd("ovf_clr_d", dout, 20'd5);
    chk1("ovf_clr_flag", ovf, 1'b0);

    // Reset one cycle after two open-burst beats.
    beat(1'b1, 1'b1, 1'b0, 8'd9, 8'd9, 8'd0);
    beat(1'b1, 1'b0, 1'b0, 8'd9, 8'd9, 8'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (ov === 1'b1) cnt++;
    end
    chkd("rstmid_no_out", AW'(cnt), 20'd0);
    chk1("rstmid_busy", busy, 1'b0);
    beat(1'b1, 1'b1, 1'b0, 8'd2, 8'd3, 8'd0);
    beat(1'b1, 1'b0, 1'b1, 8'd4, 8'd5, 8'd0);
    step(); step();
    chk1("rstmid_v", ov, 1'b1); chkd("rstmid_d", dout, 20'd26);

    // Reset after the accumulator has absorbed beats; a last-only beat starts from 0.
    beat(1'b1, 1'b1, 1'b0, 8'd9, 8'd9, 8'd0);
    beat(1'b1, 1'b0, 1'b0, 8'd9, 8'd9, 8'd0);
    step(); step();
    chk1("rstacc_busy_pre", busy, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk1("rstacc_busy", busy, 1'b0);
    beat(1'b1, 1'b0, 1'b1, 8'd1, 8'd1, 8'd0);
    step(); step();
    chk1("rstacc_v", ov, 1'b1); chkd("rstacc_d", dout, 20'd1);

    // Signed instance.
    do_reset();
    beat(1'b0, 1'b0, 1'b0, 8'h80, 8'h7F, 8'hFF);
    step(); step();
    chk1("s_mac_v", s_ov, 1'b1); chkd("s_mac_d", s_dout, 20'hFC07F);
    chk1("s_mac_ovf", s_ovf, 1'b0);
    beat(1'b1, 1'b1, 1'b1, 8'hFD, 8'd5, 8'hFE);
    step(); step();
    chk1("s_single_v", s_ov, 1'b1); chkd("s_single_d", s_dout, 20'hFFFEF);
    chk1("s_single_ovf", s_ovf, 1'b0);
    for (int i = 0; i < 32; i++) begin
      beat(1'b1, i == 0, i == 31, 8'h80, 8'h80, 8'd0);
    end
    step(); step();
    chk1("s_acc_v", s_ov, 1'b1); chkd("s_acc_d", s_dout, 20'h80000);
    chk1("s_acc_ovf", s_ovf, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
